// File: rtl/switch_pkg.sv
// Shared switch datapath defaults and word/address types.
package switch_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 12;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/ram_array.sv
// Pure storage with one write port and one registered read port; no reset so it maps onto block RAM.
module ram_array #(
    parameter int unsigned DATA_WIDTH = switch_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = switch_pkg::ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] wraddress,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  rden,
    input  logic [ADDR_WIDTH-1:0] rdaddress,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Read and write share one edge; the read samples the old word (read-before-write).
    always_ff @(posedge clock) begin
        if (wren) begin
            mem[wraddress] <= data;
        end
        if (rden) begin
            q <= mem[rdaddress];
        end
    end

endmodule

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: storage plus resettable read pipeline (1 or 2 cycle latency).
module dual_port_ram #(
    parameter int unsigned DATA_WIDTH = switch_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = switch_pkg::ADDR_WIDTH,
    parameter int unsigned OUT_REG    = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] wraddress,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] rdaddress,
    input  logic                  rden,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] stage1;
    logic                  rd_valid;

    ram_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram_array (
        .clock    (clock),
        .wren     (wren),
        .wraddress(wraddress),
        .data     (data),
        .rden     (rden),
        .rdaddress(rdaddress),
        .q        (ram_q)
    );

    // The BRAM read register cannot be reset, so a reset-able valid flag masks it to 0
    // until the first rden edge after reset; this behaves as a reset stage-1 register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= 1'b0;
        end else if (rden) begin
            rd_valid <= 1'b1;
        end
    end

    assign stage1 = rd_valid ? ram_q : '0;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] q_r;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    q_r <= '0;
                end else begin
                    q_r <= stage1;
                end
            end

            assign q = q_r;
        end else begin : g_no_out_reg
            assign q = stage1;
        end
    endgenerate

endmodule

// File: tb/tb_dual_port_ram.sv
// Bench for dual_port_ram: both OUT_REG settings side by side against a behavioural model.
module tb_dual_port_ram;
    import switch_pkg::*;

    logic  clock = 1'b0;
    logic  reset_n = 1'b0;
    word_t data = '0;
    addr_t wraddress = '0;
    logic  wren = 1'b0;
    addr_t rdaddress = '0;
    logic  rden = 1'b0;
    word_t q0;
    word_t q1;

    int checks = 0;
    int errors = 0;

    // Reference model: memory array, last value read since reset, and q1 = q0 one cycle late.
    word_t mem_m [4096];
    word_t m_q0 = '0;
    word_t m_q1 = '0;

    always #5 clock = ~clock;

    dual_port_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .OUT_REG(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .data(data), .wraddress(wraddress),
        .wren(wren), .rdaddress(rdaddress), .rden(rden), .q(q0)
    );

    dual_port_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .OUT_REG(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .data(data), .wraddress(wraddress),
        .wren(wren), .rdaddress(rdaddress), .rden(rden), .q(q1)
    );

    task automatic check(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string name);
        check({name, "/q0"}, q0, m_q0);
        check({name, "/q1"}, q1, m_q1);
    endtask

    // Entered and left at posedge+1; applies one clock edge to DUTs and model.
    task automatic cycle(input logic we, input addr_t wa, input word_t wd,
                         input logic re, input addr_t ra, input string name);
        word_t prev;
        wren = we; wraddress = wa; data = wd; rden = re; rdaddress = ra;
        @(posedge clock);
        prev = m_q0;
        if (!reset_n) begin
            m_q0 = '0;
            m_q1 = '0;
        end else begin
            if (re) m_q0 = mem_m[ra];
            m_q1 = prev;
        end
        if (we) mem_m[wa] = wd;
        #1;
        check_model(name);
    endtask

    task automatic pulse_reset(input string name);
        reset_n = 1'b0;
        m_q0 = '0;
        m_q1 = '0;
        #1;
        check_model({name, "/during"});
        reset_n = 1'b1;
        #1;
        check_model({name, "/after"});
    endtask

    typedef struct {
        logic  we;
        addr_t wa;
        word_t wd;
        logic  re;
        addr_t ra;
        word_t exp_q0;
        word_t exp_q1;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem_m[i] = '0;

        vecs[0]  = '{1'b1, 12'd5,    32'hDEADBEEF, 1'b0, 12'd0,    32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[1]  = '{1'b1, 12'd4095, 32'h00000003, 1'b1, 12'd5,    32'hDEADBEEF, 32'hA5A5A5A5};
        vecs[2]  = '{1'b0, 12'd0,    32'h0,        1'b1, 12'd4095, 32'h00000003, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 12'd7,    32'h00000011, 1'b0, 12'd0,    32'h00000003, 32'h00000003};
        vecs[4]  = '{1'b1, 12'd7,    32'h00000022, 1'b1, 12'd7,    32'h00000011, 32'h00000003};
        vecs[5]  = '{1'b0, 12'd0,    32'h0,        1'b1, 12'd7,    32'h00000022, 32'h00000011};
        vecs[6]  = '{1'b0, 12'd0,    32'h0,        1'b1, 12'd5,    32'hDEADBEEF, 32'h00000022};
        vecs[7]  = '{1'b0, 12'd0,    32'h0,        1'b0, 12'd4095, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[8]  = '{1'b0, 12'd0,    32'h0,        1'b0, 12'd4095, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[9]  = '{1'b0, 12'd0,    32'h0,        1'b0, 12'd4095, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[10] = '{1'b1, 12'd100,  32'h0BADF00D, 1'b1, 12'd4095, 32'h00000003, 32'hDEADBEEF};

        // Reset held while writing and reading: q stays 0, the write still lands.
        repeat (2) @(posedge clock);
        #1;
        check("reset/q0", q0, 32'h0);
        check("reset/q1", q1, 32'h0);
        cycle(1'b1, 12'd9, 32'hA5A5A5A5, 1'b1, 12'd9, "reset_write");
        check("reset_write/q0", q0, 32'h0);
        reset_n = 1'b1;
        #1;
        check_model("release");
        cycle(1'b0, 12'd0, 32'h0, 1'b0, 12'd9, "idle_after_release");
        check("hold_zero/q0", q0, 32'h0);
        cycle(1'b0, 12'd0, 32'h0, 1'b1, 12'd9, "first_read");
        check("first_read/q0", q0, 32'hA5A5A5A5);
        check("first_read/q1", q1, 32'h0);
        cycle(1'b0, 12'd0, 32'h0, 1'b0, 12'd9, "first_read_lat2");
        check("first_read_lat2/q1", q1, 32'hA5A5A5A5);

        // Directed write/read, collision and rden-hold vectors.
        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra, $sformatf("vec%0d", i));
            check($sformatf("vec%0d/exp_q0", i), q0, vecs[i].exp_q0);
            check($sformatf("vec%0d/exp_q1", i), q1, vecs[i].exp_q1);
        end

        // Streaming: writes 0..15 with reads lagging by two, reset pulse mid-stream.
        for (int i = 0; i < 18; i++) begin
            cycle(i < 16, addr_t'(i), word_t'(i * 3), i >= 2, addr_t'(i - 2), $sformatf("stream%0d", i));
            if (i >= 2) check($sformatf("stream%0d/exp", i), q0, word_t'((i - 2) * 3));
            if (i == 9) begin
                pulse_reset("stream_reset");
                check("stream_reset/q0_zero", q0, 32'h0);
            end
        end
        cycle(1'b0, 12'd0, 32'h0, 1'b1, 12'd10, "reread10");
        check("reread10/exp", q0, 32'd30);
        cycle(1'b0, 12'd0, 32'h0, 1'b0, 12'd10, "reread10_lat2");
        check("reread10_lat2/exp", q1, 32'd30);

        // Random traffic over a small address window to force collisions.
        for (int i = 0; i < 400; i++) begin
            addr_t wa;
            addr_t ra;
            wa = ($urandom_range(0, 7) == 0) ? 12'd4095 : addr_t'($urandom_range(0, 15));
            ra = ($urandom_range(0, 7) == 0) ? 12'd4095 : addr_t'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) ra = wa;
            cycle(1'($urandom_range(0, 1)), wa, word_t'($urandom), 1'($urandom_range(0, 2) != 0), ra,
                  $sformatf("rand%0d", i));
            if ($urandom_range(0, 49) == 0) pulse_reset($sformatf("rand_reset%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
